// File: rtl/inst_pkg.sv
// Shared constants for the instruction fetch path: default widths and the
// instruction field layout used by the head decoder.
package inst_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int INST_W_DEF = 25;
    localparam int INST_W_MIN = 25;

    localparam int OPC_LSB  = 20;
    localparam int OPC_W    = 5;
    localparam int DST_LSB  = 16;
    localparam int DST_W    = 4;
    localparam int SRC1_LSB = 12;
    localparam int SRC1_W   = 4;
    localparam int SRC2_LSB = 8;
    localparam int SRC2_W   = 4;
    // Imm shares bit 8 with Source2: R-type reads Source2, I-type reads Imm.
    localparam int IMM_LSB  = 0;
    localparam int IMM_W    = 9;

endpackage

// File: rtl/fetch_fifo.sv
// Circular queue of fetched entries with push/pop/flush; head data is read
// combinationally. A push on a full queue is accepted only alongside a pop.
module fetch_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     Reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[head];

    // Pointers are PTR_W bits wide, so DEPTH being a power of two gives the wrap for free.
    always_ff @(posedge clk) begin
        if (Reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !Reset && !flush)
            mem[tail] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: PC register driving a combinational ROM, a small
// prefetch queue, and field decode of the head instruction.
module inst_fetch_queue
    import inst_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    Reset,
    input  logic                    en,
    input  logic                    redirect,
    input  logic [ADDR_W-1:0]       redirect_addr,
    output logic [ADDR_W-1:0]       rom_addr,
    input  logic [INST_W-1:0]       rom_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [INST_W-1:0]       out_inst,
    output logic [ADDR_W-1:0]       out_pc,
    output logic [OPC_W-1:0]        opcode,
    output logic [DST_W-1:0]        Destin,
    output logic [SRC1_W-1:0]       Source1,
    output logic [SRC2_W-1:0]       Source2,
    output logic [IMM_W-1:0]        Imm,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int ENTRY_W = ADDR_W + INST_W;

    logic [ADDR_W-1:0]  pc;
    logic [ENTRY_W-1:0] head_entry;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready && !redirect;
    assign push      = en && !redirect && (!fifo_full || pop);
    assign rom_addr  = pc;

    // PC wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (Reset)
            pc <= '0;
        else if (redirect)
            pc <= redirect_addr;
        else if (push)
            pc <= pc + 1'b1;
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Reset (Reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({pc, rom_data}),
        .rdata (head_entry),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Storage is not cleared, so the head is masked whenever it is not valid.
    assign out_pc   = out_valid ? head_entry[ENTRY_W-1 -: ADDR_W] : '0;
    assign out_inst = out_valid ? head_entry[INST_W-1:0] : '0;

    assign opcode  = out_inst[OPC_LSB  +: OPC_W];
    assign Destin  = out_inst[DST_LSB  +: DST_W];
    assign Source1 = out_inst[SRC1_LSB +: SRC1_W];
    assign Source2 = out_inst[SRC2_LSB +: SRC2_W];
    assign Imm     = out_inst[IMM_LSB  +: IMM_W];

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: stimulus queues the expected fetch
// stream, a negedge monitor checks every pop and the idle-zero outputs.
module tb_inst_fetch_queue;

    localparam int ADDR_W = 8;
    localparam int INST_W = 25;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              Reset;
    logic              en;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic [4:0]        opcode;
    logic [3:0]        Destin;
    logic [3:0]        Source1;
    logic [3:0]        Source2;
    logic [8:0]        Imm;
    logic [2:0]        count;

    int   vectors     = 0;
    int   miscompares = 0;
    logic rom_mode    = 1'b0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } exp_t;

    exp_t exp_q[$];

    inst_fetch_queue #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .Reset         (Reset),
        .en            (en),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_inst      (out_inst),
        .out_pc        (out_pc),
        .opcode        (opcode),
        .Destin        (Destin),
        .Source1       (Source1),
        .Source2       (Source2),
        .Imm           (Imm),
        .count         (count)
    );

    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] rom_model(input logic [ADDR_W-1:0] a, input logic mode);
        if (mode)
            return {a, ~a, a[0], a ^ 8'hC3};
        return {17'd0, a};
    endfunction

    always_comb rom_data = rom_model(rom_addr, rom_mode);

    function automatic void push_seq(input logic [ADDR_W-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            logic [ADDR_W-1:0] a;
            a = start + 8'(i);
            exp_q.push_back('{a, rom_model(a, rom_mode)});
        end
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!Reset && !redirect && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL pop_unexpected: got pop of pc 0x%0h, required no pop", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("pop_pc", 64'(out_pc), 64'(e.pc));
                chk("pop_inst", 64'(out_inst), 64'(e.inst));
                chk("pop_fields", 64'({opcode, Destin, Source1, Source2, Imm}),
                    64'({e.inst[24:20], e.inst[19:16], e.inst[15:12], e.inst[11:8], e.inst[8:0]}));
            end
        end
        if (!out_valid)
            chk("idle_zero", 64'({out_inst, out_pc, opcode, Destin, Source1, Source2, Imm}), 64'(0));
    end

    initial begin
        Reset         = 1'b1;
        en            = 1'b0;
        redirect      = 1'b0;
        redirect_addr = '0;
        out_ready     = 1'b0;

        repeat (2) step();
        chk("rst_count", 64'(count), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_rom_addr", 64'(rom_addr), 64'(0));

        // Streaming: one push and one pop per edge, ROM[i]=i.
        push_seq(8'h00, 40);
        Reset     = 1'b0;
        en        = 1'b1;
        out_ready = 1'b1;
        step();
        chk("first_fetch_pc", 64'(out_pc), 64'(0));
        chk("first_fetch_count", 64'(count), 64'(1));
        chk("first_rom_addr", 64'(rom_addr), 64'(1));
        for (int k = 2; k <= 10; k++) begin
            step();
            chk("stream_valid", 64'(out_valid), 64'(1));
            chk("stream_pc", 64'(out_pc), 64'(k - 1));
            chk("stream_count", 64'(count), 64'(1));
        end

        // Fill to full from reset with the consumer stalled.
        Reset     = 1'b1;
        out_ready = 1'b0;
        step();
        exp_q.delete();
        push_seq(8'h00, 40);
        chk("rst2_count", 64'(count), 64'(0));
        chk("rst2_rom_addr", 64'(rom_addr), 64'(0));
        Reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("fill_count", 64'(count), 64'(k));
            chk("fill_rom_addr", 64'(rom_addr), 64'(k));
        end
        repeat (2) begin
            step();
            chk("full_hold_count", 64'(count), 64'(4));
            chk("full_hold_rom_addr", 64'(rom_addr), 64'(4));
            chk("full_hold_pc", 64'(out_pc), 64'(0));
        end

        // One pop on a full queue: push accepted alongside it.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("full_pp_count", 64'(count), 64'(4));
        chk("full_pp_pc", 64'(out_pc), 64'(1));
        chk("full_pp_rom_addr", 64'(rom_addr), 64'(5));

        // en low: pop only, PC holds.
        en        = 1'b0;
        out_ready = 1'b1;
        step();
        chk("noen_count", 64'(count), 64'(3));
        chk("noen_rom_addr", 64'(rom_addr), 64'(5));
        chk("noen_pc", 64'(out_pc), 64'(2));

        // Redirect at count=3 with push and pop otherwise possible.
        redirect      = 1'b1;
        redirect_addr = 8'h40;
        en            = 1'b1;
        step();
        chk("redir_count", 64'(count), 64'(0));
        chk("redir_valid", 64'(out_valid), 64'(0));
        chk("redir_rom_addr", 64'(rom_addr), 64'(8'h40));
        redirect = 1'b0;
        rom_mode = 1'b1;
        exp_q.delete();
        push_seq(8'h40, 20);
        step();
        chk("redir_head_pc", 64'(out_pc), 64'(8'h40));
        chk("redir_head_valid", 64'(out_valid), 64'(1));
        repeat (5) step();

        // PC wrap from 0xFF to 0x00 without a stall.
        redirect      = 1'b1;
        redirect_addr = 8'hFC;
        step();
        redirect = 1'b0;
        exp_q.delete();
        push_seq(8'hFC, 20);
        for (int k = 1; k <= 6; k++) begin
            step();
            chk("wrap_pc", 64'(out_pc), 64'(8'(8'hFB + k)));
            chk("wrap_count", 64'(count), 64'(1));
            if (k == 4)
                chk("wrap_rom_addr", 64'(rom_addr), 64'(0));
        end

        // Reset beats a simultaneous redirect at count=2.
        redirect      = 1'b1;
        redirect_addr = 8'h10;
        out_ready     = 1'b0;
        step();
        redirect = 1'b0;
        exp_q.delete();
        push_seq(8'h10, 8);
        repeat (2) step();
        chk("pre_rst_count", 64'(count), 64'(2));
        chk("pre_rst_pc", 64'(out_pc), 64'(8'h10));
        Reset         = 1'b1;
        redirect      = 1'b1;
        redirect_addr = 8'h33;
        out_ready     = 1'b1;
        step();
        chk("rst_redir_count", 64'(count), 64'(0));
        chk("rst_redir_rom_addr", 64'(rom_addr), 64'(0));
        chk("rst_redir_outs", 64'({out_valid, out_pc, out_inst}), 64'(0));
        Reset     = 1'b0;
        redirect  = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        step();
        chk("idle_count", 64'(count), 64'(0));
        chk("idle_rom_addr", 64'(rom_addr), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
